ycc422_pack: RTL and testbench



---
 rtl/isp_pkg.sv | 30 +++
 rtl/ycc422_pack_if.sv | 26 ++
 rtl/ycc_quant.sv | 39 +++
 rtl/ycc422_pack.sv | 118 +++++++++++
 tb/tb_ycc422_pack.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/isp_pkg.sv
// Shared ISP pixel-path types and constants.
// Contents: pixel/fixed-point typedefs, the packed 4:2:2 output word layout,
//           and a round-half-up 8-bit average helper.
package isp_pkg;

    localparam int unsigned PIX_W         = 8;
    localparam int unsigned FRAC          = 9;
    localparam int unsigned CHROMA_OFFSET = 128;
    localparam int unsigned ROUND_HALF    = 256;
    localparam int unsigned WORD_W        = 4 * PIX_W;

    typedef logic        [PIX_W-1:0] pix8_t;
    typedef logic signed [17:0]      fix18_t;

    // One 4:2:2 output word: {Y0, Cb, Y1, Cr}, Y0 in the top byte.
    typedef struct packed {
        pix8_t y0;
        pix8_t cb;
        pix8_t y1;
        pix8_t cr;
    } ycc422_word_t;

    // (a + b + 1) >> 1 with a 9-bit intermediate sum, so it never overflows.
    function automatic pix8_t avg_up(input pix8_t a, input pix8_t b);
        logic [PIX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + (PIX_W+1)'(1);
        return sum[PIX_W:1];
    endfunction

endpackage

// File: rtl/ycc422_pack_if.sv
// Pixel-in / packed-word-out bus for the 4:2:2 packer.
// Signals: iValid, iY, iCb, iCr   - upstream pixel (driven by master)
//          oValid, oDone, oData   - packed pair output (driven by slave)
interface ycc422_pack_if
    import isp_pkg::*;
#(
    parameter int unsigned IN_W = 18
);
    logic                   iValid;
    logic signed [IN_W-1:0] iY;
    logic signed [IN_W-1:0] iCb;
    logic signed [IN_W-1:0] iCr;
    logic                   oValid;
    logic                   oDone;
    logic [WORD_W-1:0]      oData;

    modport master (
        output iValid, iY, iCb, iCr,
        input  oValid, oDone, oData
    );

    modport slave (
        input  iValid, iY, iCb, iCr,
        output oValid, oDone, oData
    );
endinterface

// File: rtl/ycc_quant.sv
// Combinational fixed-point to 8-bit quantizer: round half up, optional
// offset, clamp to 0..255.
// Ports: din  - signed IN_W-bit fixed point with FRAC fraction bits
//        q_c  - 8-bit unsigned result (combinational)
module ycc_quant #(
    parameter int unsigned IN_W   = 18,
    parameter int unsigned FRAC   = 9,
    parameter int unsigned OFFSET = 0
) (
    input  logic signed [IN_W-1:0] din,
    output isp_pkg::pix8_t         q_c
);
    import isp_pkg::*;

    // One extra bit gives headroom for the rounding add.
    localparam int unsigned EXT_W = IN_W + 1;

    logic signed [EXT_W-1:0] ext_c;
    logic signed [EXT_W-1:0] rnd_c;
    logic signed [EXT_W-1:0] sh_c;
    logic signed [EXT_W-1:0] ofs_c;

    // Round, shift to integer, offset, then saturate.
    always_comb begin
        q_c   = '0;
        ext_c = {din[IN_W-1], din};
        rnd_c = ext_c + $signed(EXT_W'(1 << (FRAC - 1)));
        sh_c  = rnd_c >>> FRAC;
        ofs_c = sh_c + $signed(EXT_W'(OFFSET));
        if (ofs_c[EXT_W-1]) begin
            q_c = '0;
        end else if (|ofs_c[EXT_W-2:PIX_W]) begin
            q_c = '1;
        end else begin
            q_c = ofs_c[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/ycc422_pack.sv
// 4:4:4 YCbCr to packed 4:2:2 output stage.
// Stage 1 quantizes each component to 8 bits; stage 2 pairs even/odd pixels,
// averages chroma and emits one {Y0,Cb,Y1,Cr} word per pair, with column/row
// tracking and an end-of-frame pulse.
// Ports: clk, reset (async, active high)
//        bus.iValid/iY/iCb/iCr  - pixel input, no backpressure
//        bus.oValid/oDone/oData - pair output; oData holds between pulses
module ycc422_pack #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned IN_W   = 18,
    parameter int unsigned FRAC   = 9
) (
    input logic         clk,
    input logic         reset,
    ycc422_pack_if.slave bus
);
    import isp_pkg::*;

    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    pix8_t y_q_c;
    pix8_t cb_q_c;
    pix8_t cr_q_c;

    ycc_quant #(.IN_W(IN_W), .FRAC(FRAC), .OFFSET(0)) u_quant_y (
        .din (bus.iY),
        .q_c (y_q_c)
    );

    ycc_quant #(.IN_W(IN_W), .FRAC(FRAC), .OFFSET(CHROMA_OFFSET)) u_quant_cb (
        .din (bus.iCb),
        .q_c (cb_q_c)
    );

    ycc_quant #(.IN_W(IN_W), .FRAC(FRAC), .OFFSET(CHROMA_OFFSET)) u_quant_cr (
        .din (bus.iCr),
        .q_c (cr_q_c)
    );

    // Stage 1: quantized pixel plus valid.
    logic  s1_valid;
    pix8_t s1_y;
    pix8_t s1_cb;
    pix8_t s1_cr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_cb    <= '0;
            s1_cr    <= '0;
        end else begin
            s1_valid <= bus.iValid;
            if (bus.iValid) begin
                s1_y  <= y_q_c;
                s1_cb <= cb_q_c;
                s1_cr <= cr_q_c;
            end
        end
    end

    // Stage 2: position tracking and pair assembly.
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    pix8_t            hold_y;
    pix8_t            hold_cb;
    pix8_t            hold_cr;
    logic             last_col_c;
    logic             last_row_c;
    ycc422_word_t     word_c;

    always_comb begin
        last_col_c = (col == COL_W'(WIDTH - 1));
        last_row_c = (row == ROW_W'(HEIGHT - 1));
        word_c.y0  = hold_y;
        word_c.cb  = avg_up(hold_cb, s1_cb);
        word_c.y1  = s1_y;
        word_c.cr  = avg_up(hold_cr, s1_cr);
    end

    // WIDTH is even, so column parity alone tells even from odd pixels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            hold_y     <= '0;
            hold_cb    <= '0;
            hold_cr    <= '0;
            bus.oValid <= 1'b0;
            bus.oDone  <= 1'b0;
            bus.oData  <= '0;
        end else begin
            bus.oValid <= 1'b0;
            bus.oDone  <= 1'b0;
            if (s1_valid) begin
                if (!col[0]) begin
                    hold_y  <= s1_y;
                    hold_cb <= s1_cb;
                    hold_cr <= s1_cr;
                end else begin
                    bus.oValid <= 1'b1;
                    bus.oDone  <= last_col_c && last_row_c;
                    bus.oData  <= word_c;
                end

                if (last_col_c) begin
                    col <= '0;
                    row <= last_row_c ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ycc422_pack.sv
// Self-checking bench for ycc422_pack (WIDTH=4, HEIGHT=2): directed cases plus
// randomized pixels scored against an arithmetic reference model.
module tb_ycc422_pack;

    localparam int unsigned W        = 4;
    localparam int unsigned H        = 2;
    localparam int          FRAMEPIX = W * H;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ycc422_pack_if #(.IN_W(18)) bus ();

    ycc422_pack #(.WIDTH(W), .HEIGHT(H), .IN_W(18), .FRAC(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    int          total   = 0;
    int          bad     = 0;
    int          cyc     = 0;
    int          pix_idx = 0;
    int          pulses  = 0;
    int          dones   = 0;
    int          h_y, h_cb, h_cr;
    logic [31:0] last_data = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference quantizer: round half up to integer, offset, saturate.
    function automatic int q8(input int x, input int off);
        int r;
        r = ((x + 256) >>> 9) + off;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel for one cycle and update the reference model.
    task automatic send(input int y, input int cb, input int cr);
        exp_t e;
        bus.iValid = 1'b1;
        bus.iY     = 18'(y);
        bus.iCb    = 18'(cb);
        bus.iCr    = 18'(cr);
        if (pix_idx % 2 == 0) begin
            h_y  = q8(y, 0);
            h_cb = q8(cb, 128);
            h_cr = q8(cr, 128);
        end else begin
            e.data = {8'(h_y), 8'((h_cb + q8(cb, 128) + 1) / 2),
                      8'(q8(y, 0)), 8'((h_cr + q8(cr, 128) + 1) / 2)};
            e.done = (pix_idx == FRAMEPIX - 1);
            e.cyc  = cyc + 2;
            expq.push_back(e);
        end
        pix_idx = (pix_idx + 1) % FRAMEPIX;
        step();
        bus.iValid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.iValid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        expq.delete();
        pix_idx = 0;
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 && expq.size() > 0; i++) step();
        chk(tag, 32'(expq.size()), 32'd0);
        idle(3);
    endtask

    function automatic int rand_comp();
        logic signed [17:0] v;
        v = 18'($urandom);
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 131071 : -131072;
        return int'(v);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("rst_valid", 32'(bus.oValid), 32'd0);
            chk("rst_done",  32'(bus.oDone),  32'd0);
            chk("rst_data",  bus.oData,       32'd0);
            last_data = '0;
        end else if (bus.oValid) begin
            pulses++;
            if (bus.oDone) dones++;
            if (expq.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("data",    bus.oData,        e.data);
                chk("done",    32'(bus.oDone),   32'(e.done));
                chk("latency", 32'(cyc),         32'(e.cyc));
            end
            last_data = bus.oData;
        end else begin
            chk("idle_done", 32'(bus.oDone), 32'd0);
            chk("hold_data", bus.oData,      last_data);
        end
    end

    initial begin
        int p0, d0, gap;
        bus.iValid = 1'b0;
        bus.iY     = '0;
        bus.iCb    = '0;
        bus.iCr    = '0;
        step();
        step();
        reset = 1'b0;
        idle(2);

        // Basic pair.
        send(51456, 5120, -10240);
        send(-1536, 6144, -10496);
        drain("t1_drain");
        chk("t1_word", last_data, {8'd101, 8'd139, 8'd0, 8'd108});

        // Saturation.
        send(131021, 102400, -102400);
        send(131021, 102400, -102400);
        drain("t2_drain");
        chk("t2_word", last_data, {8'd255, 8'd255, 8'd255, 8'd0});

        // Gapped input.
        p0 = pulses;
        idle(5);
        send(51456, 5120, -10240);
        idle(3);
        send(-1536, 6144, -10496);
        drain("t3_drain");
        chk("t3_pulses", 32'(pulses - p0), 32'd1);
        chk("t3_word", last_data, {8'd101, 8'd139, 8'd0, 8'd108});

        // Chroma average rounding.
        send(0, 0, -60416);
        send(0, 512, -59904);
        drain("t4_drain");
        chk("t4_word", last_data, {8'd0, 8'd129, 8'd0, 8'd11});

        // Frame boundary: one full frame, then one more pair.
        do_reset();
        p0 = pulses;
        d0 = dones;
        for (int i = 0; i < FRAMEPIX; i++) send(rand_comp(), rand_comp(), rand_comp());
        drain("t5_drain_a");
        chk("t5_pulses", 32'(pulses - p0), 32'd4);
        chk("t5_dones",  32'(dones - d0),  32'd1);
        p0 = pulses;
        d0 = dones;
        send(rand_comp(), rand_comp(), rand_comp());
        send(rand_comp(), rand_comp(), rand_comp());
        drain("t5_drain_b");
        chk("t5_wrap_pulses", 32'(pulses - p0), 32'd1);
        chk("t5_wrap_dones",  32'(dones - d0),  32'd0);

        // Reset mid-pair: held even pixel must be discarded.
        do_reset();
        send(102400, 20000, -20000);
        idle(1);
        do_reset();
        p0 = pulses;
        send(5120, 0, 0);
        send(10240, 0, 0);
        drain("t6_drain");
        chk("t6_pulses", 32'(pulses - p0), 32'd1);
        chk("t6_word", last_data, {8'd10, 8'd128, 8'd20, 8'd128});

        // Randomized stream with gaps and one reset in the middle.
        do_reset();
        for (int i = 0; i < 240; i++) begin
            if (i == 121) do_reset();
            send(rand_comp(), rand_comp(), rand_comp());
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (gap > 0) idle(gap);
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
